// File: rtl/cevero_mem_pkg.sv
// Shared types for the cevero memory responder.
// Optional per-byte parity is enabled by defining CEVERO_MEM_PARITY_EN.
package cevero_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [0:0] {IDLE, STALL} mem_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] rdata;
        logic              err;
    } mem_rsp_t;

    // Even parity per byte: each bit makes its byte plus parity hold an even number of ones.
    function automatic logic [BE_W-1:0] byte_parity(input logic [WORD_W-1:0] word);
        logic [BE_W-1:0] par;
        for (int b = 0; b < BE_W; b++) begin
            par[b] = ^word[8*b +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/cevero_mem_array.sv
// Word storage with byte-enable writes and combinational read.
// Per-byte parity storage and check exist only when CEVERO_MEM_PARITY_EN is defined.
module cevero_mem_array
    import cevero_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BE_W-1:0]   be,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rd_err,
    output logic [WORD_W-1:0] word0,
    output logic [WORD_W-1:0] word1
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Only the mailbox words are cleared; the rest of the image survives reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];
    assign word0 = mem[0];
    assign word1 = mem[1];

`ifdef CEVERO_MEM_PARITY_EN
    logic [BE_W-1:0] par [DEPTH];
    logic [BE_W-1:0] wpar;

    assign wpar = byte_parity(wdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            par[0] <= '0;
            par[1] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    par[addr][b] <= wpar[b];
                end
            end
        end
    end

    assign rd_err = |(byte_parity(rdata) ^ par[addr]);
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: rtl/cevero_mem_responder.sv
// Request/grant/rvalid memory responder with optional grant stalls and a done/result mailbox.
// Parity checking of stored words is enabled by defining CEVERO_MEM_PARITY_EN.
module cevero_mem_responder
    import cevero_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o,
    output logic              done_o,
    output logic [WORD_W-1:0] result_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    mem_state_e        state_q;
    logic [3:0]        cnt_q;
    logic              gnt;
    logic              in_range;
    logic              wr_en;
    logic              rd_err;
    logic [WORD_W-1:0] rd_data;
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
    mem_rsp_t          rsp_d;
    mem_rsp_t          rsp_q;
    logic              rvalid_q;
    logic              unused_addr;

    assign unused_addr = ^addr_i[1:0];
    assign in_range    = addr_i[31:2] < 30'(DEPTH);

    // cnt_q counts remaining stall cycles including the current one; it hits zero with the grant.
    always_comb begin
        gnt = 1'b0;
        if (!rst_i && req_i) begin
            case (state_q)
                IDLE:    gnt = (WAIT_CYCLES == 0);
                STALL:   gnt = (cnt_q == 4'd1);
                default: gnt = 1'b0;
            endcase
        end
    end

    assign wr_en = gnt & we_i & in_range;

    always_comb begin
        rsp_d = '0;
        if (!we_i && in_range) begin
            rsp_d.rdata = rd_data;
        end
        rsp_d.err = !in_range || (!we_i && rd_err);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            rvalid_q <= gnt;
            rsp_q    <= gnt ? rsp_d : '0;
            case (state_q)
                IDLE: begin
                    if (req_i && WAIT_CYCLES != 0) begin
                        state_q <= STALL;
                        cnt_q   <= 4'(WAIT_CYCLES);
                    end
                end
                STALL: begin
                    // A dropped request abandons the transfer without a response.
                    if (!req_i || gnt) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    cevero_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr_en  (wr_en),
        .be     (be_i),
        .addr   (addr_i[AW+1:2]),
        .wdata  (wdata_i),
        .rdata  (rd_data),
        .rd_err (rd_err),
        .word0  (word0),
        .word1  (word1)
    );

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rsp_q.rdata;
    assign err_o    = rsp_q.err;
    assign done_o   = (word0 == 32'd1);
    assign result_o = word1;

endmodule

// File: tb/tb_cevero_mem_responder.sv
// Bench for cevero_mem_responder: a zero-wait instance checked every cycle against a word-array
// model, plus a three-wait-cycle instance checked with directed timing sequences.
module tb_cevero_mem_responder;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0, we0, gnt0, rvalid0, err0, done0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0, rdata0, result0;
    logic        req3, we3, gnt3, rvalid3, err3, done3;
    logic [3:0]  be3;
    logic [31:0] addr3, wdata3, rdata3, result3;

    cevero_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0), .be_i(be0), .addr_i(addr0),
        .wdata_i(wdata0), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0),
        .done_o(done0), .result_o(result0)
    );

    cevero_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .we_i(we3), .be_i(be3), .addr_i(addr3),
        .wdata_i(wdata3), .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3),
        .done_o(done3), .result_o(result3)
    );

    int vectors = 0;
    int errors  = 0;
    bit check_en = 1'b0;

    // Reference model: plain word array plus a per-byte "corrupted" mask.
    logic [31:0] mm  [DEPTH];
    logic [3:0]  bad [DEPTH];
    logic        exp_rvalid = 1'b0;
    logic [31:0] exp_rdata  = '0;
    logic        exp_err    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int unsigned idx;
        if (rst) begin
            exp_rvalid = 1'b0;
            mm[0] = '0;
            mm[1] = '0;
            bad[0] = '0;
            bad[1] = '0;
        end else begin
            exp_rvalid = req0;
            if (req0) begin
                idx = 32'(addr0[31:2]);
                if (idx >= DEPTH) begin
                    exp_rdata = '0;
                    exp_err   = 1'b1;
                end else if (we0) begin
                    exp_rdata = '0;
                    exp_err   = 1'b0;
                    for (int b = 0; b < 4; b++) begin
                        if (be0[b]) begin
                            mm[idx][8*b +: 8] = wdata0[8*b +: 8];
                            bad[idx][b] = 1'b0;
                        end
                    end
                end else begin
                    exp_rdata = mm[idx];
                    exp_err   = |bad[idx];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("gnt", 32'(gnt0), 32'(req0 & ~rst));
            chk("rvalid", 32'(rvalid0), 32'(exp_rvalid));
            if (exp_rvalid) begin
                chk("rdata", rdata0, exp_rdata);
                chk("err", 32'(err0), 32'(exp_err));
            end
            chk("done", 32'(done0), 32'(mm[0] == 32'd1));
            chk("result", result0, mm[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        req0 = r; we0 = w; addr0 = a; wdata0 = d; be0 = b;
    endtask

    // One access on the stalled instance: grant exactly three cycles in, one-cycle rvalid after.
    task automatic acc3(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] exp_d, input logic exp_e);
        req3 = 1'b1; we3 = w; addr3 = a; wdata3 = d; be3 = b;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("gnt3_latency", 32'(gnt3), 32'(k == 3));
            chk("rvalid3_early", 32'(rvalid3), 32'd0);
            step();
        end
        req3 = 1'b0;
        @(negedge clk);
        chk("rvalid3", 32'(rvalid3), 32'd1);
        chk("rdata3", rdata3, exp_d);
        chk("err3", 32'(err3), 32'(exp_e));
        step();
        @(negedge clk);
        chk("rvalid3_pulse", 32'(rvalid3), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [31:0] v;
        int unsigned widx;

        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = '0;
            bad[i] = '0;
        end
        rst = 1'b1;
        drive0(1'b0, 1'b0, '0, '0, '0);
        req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0; be3 = '0;
        step();
        step();
        rst = 1'b0;
        check_en = 1'b1;

        // Fill the image, then reset so the mailbox words start cleared.
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 5) ? 32'hDEADBEEF : $urandom;
            drive0(1'b1, 1'b1, 32'(i * 4), v, 4'hF);
            step();
        end
        drive0(1'b0, 1'b0, '0, '0, '0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Read of preloaded word 5.
        drive0(1'b1, 1'b0, 32'd20, '0, '0);
        @(negedge clk);
        chk("t1_gnt", 32'(gnt0), 32'd1);
        step();
        drive0(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("t1_rvalid", 32'(rvalid0), 32'd1);
        chk("t1_rdata", rdata0, 32'hDEADBEEF);
        chk("t1_err", 32'(err0), 32'd0);
        step();

        // Mailbox: partial result write, then done flag.
        drive0(1'b1, 1'b1, 32'd4, 32'h0000_002A, 4'b0011);
        step();
        drive0(1'b1, 1'b1, 32'd0, 32'd1, 4'hF);
        @(negedge clk);
        chk("t2_done_early", 32'(done0), 32'd0);
        step();
        drive0(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("t2_done", 32'(done0), 32'd1);
        chk("t2_result", result0, 32'h2A);
        step();

        // Out-of-range read and write.
        drive0(1'b1, 1'b0, 32'(DEPTH * 4), '0, '0);
        step();
        drive0(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("oor_err", 32'(err0), 32'd1);
        chk("oor_rdata", rdata0, 32'd0);
        step();
        drive0(1'b1, 1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF);
        step();
        drive0(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("oor_wr_result", result0, 32'h2A);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            drive0(1'b1, 1'b0, 32'(i * 4), '0, '0);
            step();
        end
        drive0(1'b0, 1'b0, '0, '0, '0);
        step();

        // Ten back-to-back reads.
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) drive0(1'b1, 1'b0, 32'((2 + i) * 4), '0, '0);
            else drive0(1'b0, 1'b0, '0, '0, '0);
            @(negedge clk);
            if (i >= 1 && rvalid0) cnt++;
            step();
        end
        chk("b2b_count", 32'(cnt), 32'd10);

        // Reset lands on the fifth grant of a burst.
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive0(1'b1, 1'b0, 32'((2 + i) * 4), '0, '0);
            else drive0(1'b0, 1'b0, '0, '0, '0);
            rst = (i == 4);
            @(negedge clk);
            if (i >= 1 && rvalid0) cnt++;
            step();
        end
        rst = 1'b0;
        chk("rst_burst_count", 32'(cnt), 32'd4);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_result", result0, 32'd0);

        // Randomized traffic, including occasional resets and out-of-range addresses.
        for (int n = 0; n < 500; n++) begin
            widx = $urandom_range(0, DEPTH + 3);
            v = $urandom;
            if (widx == 0 && $urandom_range(0, 1) == 0) v = 32'd1;
            drive0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0) ? $urandom : ((widx << 2) | $urandom_range(0, 3)),
                   v, 4'($urandom_range(0, 15)));
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        drive0(1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
        step();

`ifdef CEVERO_MEM_PARITY_EN
        drive0(1'b1, 1'b1, 32'd12, 32'h1234_5678, 4'hF);
        step();
        drive0(1'b0, 1'b0, '0, '0, '0);
        step();
        dut0.u_array.mem[3] = dut0.u_array.mem[3] ^ 32'h0000_0200;
        mm[3] = mm[3] ^ 32'h0000_0200;
        bad[3][1] = 1'b1;
        drive0(1'b1, 1'b0, 32'd12, '0, '0);
        step();
        drive0(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("par_rdata", rdata0, 32'h1234_5478);
        chk("par_err", 32'(err0), 32'd1);
        step();
        drive0(1'b1, 1'b1, 32'd12, 32'h0000_5600, 4'b0010);
        step();
        drive0(1'b1, 1'b0, 32'd12, '0, '0);
        step();
        drive0(1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("par_fixed_rdata", rdata0, 32'h1234_5678);
        chk("par_fixed_err", 32'(err0), 32'd0);
        step();
`endif

        // Stalled instance: latency, data, abandoned request, out of range.
        acc3(1'b1, 32'd8, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
        acc3(1'b0, 32'd8, '0, '0, 32'hCAFE_F00D, 1'b0);
        req3 = 1'b1; we3 = 1'b0; addr3 = 32'd8;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("drop_gnt", 32'(gnt3), 32'd0);
            step();
        end
        req3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("drop_gnt_after", 32'(gnt3), 32'd0);
            chk("drop_rvalid", 32'(rvalid3), 32'd0);
            step();
        end
        acc3(1'b0, 32'd8, '0, '0, 32'hCAFE_F00D, 1'b0);
        acc3(1'b0, 32'(DEPTH * 4), '0, '0, 32'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
